piso: RTL and testbench
=======================

# piso

Parallel-in, serial-out framer: the transmit counterpart of the 1-bit-wide `sipo`. Accepts `width_p`-bit result words from the systolic array's output `fifo` over a ready/valid handshake and emits them one bit per output handshake, MSB first. Output is grouped into frames of `words_per_frame_p` words, with start- and end-of-frame markers. A one-word holding register lets the next word be accepted while the current word is shifting, so frames stream back-to-back with no gap.

## Interface
- `width_p`, 8: word width in bits; must be ≥ 2.
- `words_per_frame_p`, 4: words per frame (`array_width_p*array_height_p`); must be ≥ 1.
- `clk_i` in 1: the single clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `flush_i` in 1: synchronous abort. Discards held and in-flight data and restarts the frame.
- `ready_o` out 1: holding register can accept a word.
- `valid_i` in 1: `data_i` is valid.
- `data_i` in `width_p`: parallel word.
- `valid_o` out 1: `data_o` holds a valid bit.
- `data_o` out 1: current serial bit.
- `yumi_i` in 1: consumer takes `data_o` this cycle. Legal only while `valid_o` = 1.
- `first_o` out 1: current bit is bit 0 of word 0 of a frame.
- `last_o` out 1: current bit is the final bit of the final word of a frame.
- `busy_o` out 1: any data is held or shifting.

## Operation
- **State.** Holding register `hold_r` with flag `hold_v_r`. Shift register `sr_r`. State enum IDLE/SHIFT. Bit counter `bit_cnt_r` is `$clog2(width_p)` bits. Word counter `word_cnt_r` is `max(1,$clog2(words_per_frame_p))` bits.
- **Input handshake.** `ready_o = ~hold_v_r & ~flush_i`. A word is accepted when `valid_i & ready_o`: `hold_r <= data_i`, `hold_v_r <= 1`.
- **Load.** A load happens in either of two cases:
  - state is IDLE and `hold_v_r` = 1;
  - state is SHIFT, `yumi_i` = 1, and `bit_cnt_r` = `width_p`-1, with `hold_v_r` = 1.

  On load: `sr_r <= hold_r`, `hold_v_r <= 0`, `bit_cnt_r <= 0`, state becomes SHIFT. Accept and load never coincide on the holding register, because `ready_o` = 0 whenever `hold_v_r` = 1.
- **Shift.** In SHIFT, when `yumi_i` = 1:
  - `sr_r` shifts left by 1.
  - `bit_cnt_r` increments, wrapping from `width_p`-1 to 0.
  - On that wrap, `word_cnt_r` increments, wrapping from `words_per_frame_p`-1 to 0.
  - If the word ends and no load occurs, state becomes IDLE.
- **Outputs.**
  - `valid_o` = (state == SHIFT).
  - `data_o` = `sr_r[width_p-1]`.
  - `first_o` = `valid_o & bit_cnt_r==0 & word_cnt_r==0`.
  - `last_o` = `valid_o & bit_cnt_r==width_p-1 & word_cnt_r==words_per_frame_p-1`.
  - `busy_o` = `valid_o | hold_v_r`.
- **Flush.** `flush_i` has priority over accept, load and yumi. On the next edge: `hold_v_r` = 0, state IDLE, both counters 0, `sr_r` = 0. A `valid_i` presented during flush is not accepted.
- **Illegal input.** `yumi_i` while `valid_o` = 0 is ignored.
- **Frame position.** The word counter persists across idle gaps. Frame position is lost only on reset or flush.

## Timing
- **Reset values.** `ready_o` = 1, `valid_o` = 0, `data_o` = 0, `first_o` = 0, `last_o` = 0, `busy_o` = 0. Counters are 0 and state is IDLE.
- **Latency.** A word accepted at edge N is loaded at edge N+1, and `valid_o` rises in the cycle after edge N+1 (2 cycles from accept).
- **Throughput.** With `yumi_i` held high, one bit per cycle. A word takes `width_p` cycles. Successive words are contiguous if the next word was accepted at least 1 cycle before the last-bit yumi.
- **Ready.** `ready_o` recovers the cycle after a load, so a second word may be accepted while the first is shifting.
- **Stalls.** When `yumi_i` is low, all outputs hold steady.
- **Combinational paths.** Only `flush_i` → `ready_o`. All other outputs are decoded from registers only.
- **Reset mid-operation.** Returns immediately (asynchronously) to the reset values. The frame restarts at word 0.

## Structure
- **Shared package** `systolic_pkg`: `piso_state_e` {IDLE, SHIFT}.
- **Sub-module** `wrap_counter`, parameters `max_val_p` and `width_p`, ports `clk_i`/`reset_i`/`clear_i`/`en_i`/`count_o`/`wrap_o`. Instantiated twice: once for bits, once for words. Its async reset sets the count to 0; `clear_i` driven by flush does the same synchronously.

## Test plan
- **Single word.** Reset; accept 0xA5 with `yumi_i` = 1.
  - `valid_o` rises 2 cycles after accept.
  - `data_o` = 1,0,1,0,0,1,0,1.
  - `first_o` is high on the first bit; `last_o` stays 0; state returns to IDLE.
- **Full frame, back-to-back.** Send 0x01, 0x02, 0x03, 0x04 with `valid_i` always high.
  - 32 contiguous valid bits with no bubble.
  - `first_o` at bit 0; `last_o` at bit 31; `ready_o` drops only while the holding register is full.
- **Backpressure.** Send 0xF0; hold `yumi_i` low for 5 cycles after the first bit.
  - `data_o` = 1 and `valid_o` = 1 stay stable.
  - The bit counter does not advance; the remaining bits follow in order.
- **Flush mid-word.** Flush after 3 bits of word 1, with word 2 held.
  - Next cycle: `valid_o` = 0, `busy_o` = 0, `ready_o` = 1.
  - The next accepted word asserts `first_o`.
- **Async reset mid-frame.**
  - Outputs go to their reset values without waiting for a clock edge.
  - A valid `yumi_i` right after release is ignored.
- **Illegal yumi / flush contention.**
  - `yumi_i` pulsed while idle changes nothing.
  - `valid_i` coincident with `flush_i` is dropped (`busy_o` stays 0).

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: types shared across the systolic array blocks.
package systolic_pkg;
  typedef enum logic {IDLE, SHIFT} piso_state_e;
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: enabled counter 0..max_val_p with synchronous clear; wrap_o flags terminal count.
module wrap_counter #(
  parameter int max_val_p = 7,
  parameter int width_p   = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               en_i,
  output logic [width_p-1:0] count_o,
  output logic               wrap_o
);
  localparam logic [width_p-1:0] max_lp = width_p'(max_val_p);
  logic [width_p-1:0] count_q, count_d;
  assign count_o = count_q;
  assign wrap_o  = count_q == max_lp;
  always_comb count_d = clear_i ? '0 : en_i ? (wrap_o ? '0 : count_q + 1'b1) : count_q;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/piso.sv
// piso: parallel-in serial-out framer, MSB first, with a one-word holding register
// so consecutive words stream without a gap.
module piso
  import systolic_pkg::*;
#(
  parameter int width_p           = 8,
  parameter int words_per_frame_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               flush_i,
  output logic               ready_o,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               valid_o,
  output logic               data_o,
  input  logic               yumi_i,
  output logic               first_o,
  output logic               last_o,
  output logic               busy_o
);
  localparam int bw_lp = $clog2(width_p);
  localparam int ww_lp = words_per_frame_p > 1 ? $clog2(words_per_frame_p) : 1;
  piso_state_e state_q, state_d;
  logic [width_p-1:0] hold_q, hold_d, sr_q, sr_d;
  logic hold_v_q, hold_v_d;
  logic [bw_lp-1:0] bit_cnt;
  logic [ww_lp-1:0] word_cnt;
  logic bit_max, word_max, shift_en, word_end, load, accept;
  assign shift_en = (state_q == SHIFT) & yumi_i & ~flush_i;
  assign word_end = shift_en & bit_max;
  assign load     = hold_v_q & ((state_q == IDLE) | word_end);
  assign accept   = valid_i & ready_o;
  wrap_counter #(.max_val_p(width_p-1), .width_p(bw_lp)) bit_ctr (
    .clk_i(clk_i), .reset_i(reset_i), .clear_i(flush_i), .en_i(shift_en),
    .count_o(bit_cnt), .wrap_o(bit_max)
  );
  wrap_counter #(.max_val_p(words_per_frame_p-1), .width_p(ww_lp)) word_ctr (
    .clk_i(clk_i), .reset_i(reset_i), .clear_i(flush_i), .en_i(word_end),
    .count_o(word_cnt), .wrap_o(word_max)
  );
  // Load takes priority over the end-of-word return to IDLE so frames stay contiguous.
  always_comb begin
    state_d  = flush_i ? IDLE : load ? SHIFT : word_end ? IDLE : state_q;
    hold_v_d = ~flush_i & (accept | (hold_v_q & ~load));
    hold_d   = accept ? data_i : hold_q;
    sr_d     = flush_i ? '0 : load ? hold_q : shift_en ? sr_q << 1 : sr_q;
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      sr_q     <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      sr_q     <= sr_d;
    end
  assign ready_o = ~hold_v_q & ~flush_i;
  assign valid_o = state_q == SHIFT;
  assign data_o  = sr_q[width_p-1];
  assign first_o = valid_o & (bit_cnt == '0) & (word_cnt == '0);
  assign last_o  = valid_o & bit_max & word_max;
  assign busy_o  = valid_o | hold_v_q;
endmodule

// File: tb/tb_piso.sv
// tb_piso: random and directed stimulus against a word-queue reference model of piso.
module tb_piso;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int FB = W * N;
  logic clk_i = 0, reset_i = 1, flush_i = 0, valid_i = 0, yumi_i = 0;
  logic [W-1:0] data_i = '0;
  logic ready_o, valid_o, data_o, first_o, last_o, busy_o;
  int errors = 0, checks = 0;
  typedef struct {logic [W-1:0] w; int acc; int vis;} ent_t;
  ent_t q[$];
  int e = 0, bi = 0, pos = 0;

  piso #(.width_p(W), .words_per_frame_p(N)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i), .ready_o(ready_o),
    .valid_i(valid_i), .data_i(data_i), .valid_o(valid_o), .data_o(data_o),
    .yumi_i(yumi_i), .first_o(first_o), .last_o(last_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // A word is visible once loaded: one edge after accept, or at the edge its predecessor finished.
  function automatic logic mvf();
    return q.size() > 0 && e >= q[0].vis;
  endfunction

  function automatic logic heldf();
    return q.size() > (mvf() ? 1 : 0);
  endfunction

  task automatic check_outputs();
    logic mv;
    mv = mvf();
    chk("valid", valid_o, mv);
    chk("busy", busy_o, q.size() > 0);
    if (mv) chk("data", data_o, q[0].w[W-1-bi]);
    else chk("data_idle", data_o, 0);
    chk("first", first_o, mv && pos % FB == 0);
    chk("last", last_o, mv && pos % FB == FB - 1);
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input logic y, input logic f, output logic acc);
    logic mv;
    valid_i = v; data_i = d; yumi_i = y; flush_i = f;
    #1;
    mv  = mvf();
    acc = v && !f && !heldf();
    chk("ready", ready_o, !f && !heldf());
    @(posedge clk_i);
    e++;
    if (f) begin
      q.delete(); bi = 0; pos = 0;
    end else begin
      if (y && mv) begin
        bi++; pos++;
        if (bi == W) begin
          bi = 0;
          void'(q.pop_front());
          if (q.size() > 0) q[0].vis = (q[0].acc + 1 > e) ? q[0].acc + 1 : e;
        end
      end
      if (acc) q.push_back('{d, e, e + 1});
    end
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic run(input logic v, input logic [W-1:0] d, input logic y, input logic f, input int n);
    logic a;
    for (int i = 0; i < n; i++) step(v, d, y, f, a);
  endtask

  task automatic pulse_reset();
    #2;
    valid_i = 0; yumi_i = 0; flush_i = 0;
    reset_i = 1;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_first", first_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", ready_o, 1);
    q.delete(); bi = 0; pos = 0;
    @(negedge clk_i);
    reset_i = 0;
  endtask

  initial begin
    logic a;
    int k;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("init_ready", ready_o, 1);
    reset_i = 0;
    check_outputs();
    step(1, 8'hA5, 1, 0, a);
    run(0, 0, 1, 0, 10);
    step(0, 0, 0, 1, a);
    k = 1;
    for (int i = 0; i < 60 && k <= N; i++) begin
      step(1, W'(k), 1, 0, a);
      if (a) k++;
    end
    chk("frame_accepts", k, N + 1);
    run(0, 0, 1, 0, 36);
    step(1, 8'hF0, 0, 0, a);
    run(0, 0, 0, 0, 6);
    run(0, 0, 1, 0, 9);
    step(1, 8'h3C, 1, 0, a);
    run(0, 0, 1, 0, 1);
    step(1, 8'hC3, 1, 0, a);
    run(0, 0, 1, 0, 2);
    step(0, 0, 0, 1, a);
    step(1, 8'h5A, 1, 0, a);
    run(0, 0, 1, 0, 12);
    run(0, 0, 1, 0, 3);
    step(1, 8'hFF, 0, 1, a);
    run(0, 0, 0, 0, 2);
    step(1, 8'h96, 1, 0, a);
    step(1, 8'h69, 1, 0, a);
    run(1, 8'h69, 1, 0, 4);
    pulse_reset();
    run(0, 0, 1, 0, 3);
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) pulse_reset();
      step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 99) == 0, a);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
